// File: rtl/kp_window_buffer_if.sv
// Pixel stream in / 3x3 window out bundle for kp_window_buffer.
// The source drives the i_* signals and the window buffer drives the o_* signals.
interface kp_window_buffer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_LENGTH = 640
);
  localparam int COL_W = $clog2(LINE_LENGTH);

  logic                    i_valid;
  logic                    i_sof;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    o_valid;
  logic [9*DATA_WIDTH-1:0] o_window;
  logic                    o_interior;
  logic [COL_W-1:0]        o_col;
  logic                    o_eol;

  modport master (
    output i_valid, i_sof, i_data,
    input  o_valid, o_window, o_interior, o_col, o_eol
  );

  modport slave (
    input  i_valid, i_sof, i_data,
    output o_valid, o_window, o_interior, o_col, o_eol
  );
endinterface

// File: rtl/kp_window_buffer.sv
// 3x3 raster-order neighbourhood generator: two line memories feed a tap array,
// and out-of-frame taps are zeroed or replicated from the nearest in-frame pixel.
module kp_window_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_LENGTH = 640,
  parameter int BORDER_MODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  kp_window_buffer_if.slave pix
);
  localparam int               COL_W    = $clog2(LINE_LENGTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LENGTH - 1);

  logic             accept;
  logic [COL_W-1:0] cur_x;
  logic [1:0]       cur_y;
  logic [COL_W-1:0] x_q, x_d;
  logic [1:0]       y_q, y_d;

  // A pixel arriving together with reset is dropped.
  assign accept = pix.i_valid && !i_rst;
  assign cur_x  = pix.i_sof ? '0 : x_q;
  assign cur_y  = pix.i_sof ? 2'd0 : y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (cur_x == LAST_COL) begin
        x_d = '0;
        y_d = (cur_y == 2'd2) ? 2'd2 : cur_y + 2'd1;
      end else begin
        x_d = cur_x + COL_W'(1);
        y_d = cur_y;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  logic [DATA_WIDTH-1:0] lb0_mem [LINE_LENGTH];
  logic [DATA_WIDTH-1:0] lb1_mem [LINE_LENGTH];
  logic [DATA_WIDTH-1:0] lb0_rd_q, lb1_rd_q, pix_q;
  logic                  lb1_wr_q;
  logic [COL_W-1:0]      lb1_addr_q;

  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb0_mem[cur_x] <= pix.i_data;
    end
  end

  // LB1 takes the old LB0 word one cycle later, straight from the LB0 read register.
  always_ff @(posedge i_clk) begin
    if (lb1_wr_q) begin
      lb1_mem[lb1_addr_q] <= lb0_rd_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lb0_rd_q   <= '0;
      lb1_rd_q   <= '0;
      pix_q      <= '0;
      lb1_wr_q   <= 1'b0;
      lb1_addr_q <= '0;
    end else begin
      lb1_wr_q <= accept;
      if (accept) begin
        lb0_rd_q   <= lb0_mem[cur_x];
        lb1_rd_q   <= lb1_mem[cur_x];
        pix_q      <= pix.i_data;
        lb1_addr_q <= cur_x;
      end
    end
  end

  logic [2:0][2:0][DATA_WIDTH-1:0] raw;

  assign raw[0][2] = lb1_rd_q;
  assign raw[1][2] = lb0_rd_q;
  assign raw[2][2] = pix_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] sh0_q, sh1_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sh0_q <= '0;
          sh1_q <= '0;
        end else if (accept) begin
          sh0_q <= sh1_q;
          sh1_q <= raw[gi][2];
        end
      end

      assign raw[gi][0] = sh0_q;
      assign raw[gi][1] = sh1_q;
    end
  endgenerate

  logic             valid_q, interior_q, eol_q;
  logic [COL_W-1:0] col_q;
  logic [1:0]       xe_q, ye_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      interior_q <= 1'b0;
      eol_q      <= 1'b0;
      col_q      <= '0;
      xe_q       <= 2'd0;
      ye_q       <= 2'd0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        col_q      <= cur_x;
        xe_q       <= (cur_x >= COL_W'(2)) ? 2'd2 : cur_x[1:0];
        ye_q       <= cur_y;
        interior_q <= (cur_x >= COL_W'(2)) && (cur_y == 2'd2);
        eol_q      <= (cur_x == LAST_COL);
      end
    end
  end

  logic [8:0][DATA_WIDTH-1:0] win;

  // Each tap checks whether its source column/row lies inside the frame.
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam int R = gi / 3;
      localparam int C = gi % 3;
      logic col_ok, row_ok;

      assign col_ok = (3'(C) + {1'b0, xe_q}) >= 3'd2;
      assign row_ok = (3'(R) + {1'b0, ye_q}) >= 3'd2;

      if (BORDER_MODE == 0) begin : g_zero
        assign win[gi] = (col_ok && row_ok) ? raw[R][C] : '0;
      end else begin : g_rep
        logic [1:0] sr, sc;
        assign sc      = col_ok ? 2'(C) : 2'd2 - xe_q;
        assign sr      = row_ok ? 2'(R) : 2'd2 - ye_q;
        assign win[gi] = raw[sr][sc];
      end
    end
  endgenerate

  assign pix.o_valid    = valid_q;
  assign pix.o_window   = win;
  assign pix.o_interior = interior_q;
  assign pix.o_col      = col_q;
  assign pix.o_eol      = valid_q && eol_q;
endmodule

// File: tb/tb_kp_window_buffer.sv
// Directed bench for kp_window_buffer on a 4x4 frame, run with zero and replicate borders.
// Per-pixel checks against a coordinate-based reference plus a hand-computed vector table.
module tb_kp_window_buffer;
  localparam int DW = 8;
  localparam int LL = 4;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          sof;
  logic [DW-1:0] data;

  int checks = 0;
  int passes = 0;

  kp_window_buffer_if #(.DATA_WIDTH(DW), .LINE_LENGTH(LL)) if0 ();
  kp_window_buffer_if #(.DATA_WIDTH(DW), .LINE_LENGTH(LL)) if1 ();

  assign if0.i_valid = valid;
  assign if0.i_sof   = sof;
  assign if0.i_data  = data;
  assign if1.i_valid = valid;
  assign if1.i_sof   = sof;
  assign if1.i_data  = data;

  kp_window_buffer #(.DATA_WIDTH(DW), .LINE_LENGTH(LL), .BORDER_MODE(0)) dut0 (
    .i_clk(clk),
    .i_rst(rst),
    .pix  (if0.slave)
  );

  kp_window_buffer #(.DATA_WIDTH(DW), .LINE_LENGTH(LL), .BORDER_MODE(1)) dut1 (
    .i_clk(clk),
    .i_rst(rst),
    .pix  (if1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          idx;
    int          mode;
    logic [71:0] win;
    logic        interior;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vt [NVEC];

  logic [71:0] cap0 [16];
  logic [71:0] cap1 [16];
  logic        capi [16];

  function automatic logic [71:0] pk(input logic [7:0] a0, input logic [7:0] a1,
                                     input logic [7:0] a2, input logic [7:0] a3,
                                     input logic [7:0] a4, input logic [7:0] a5,
                                     input logic [7:0] a6, input logic [7:0] a7,
                                     input logic [7:0] a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Reference window from frame coordinates: pixel value = base + 16*y + x.
  function automatic logic [71:0] ref_win(input int x, input int y, input int mode, input int base);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int  sx;
        int  sy;
        bit  out;
        sx  = x - 2 + c;
        sy  = y - 2 + r;
        out = (sx < 0) || (sy < 0);
        if (sx < 0) sx = 0;
        if (sy < 0) sy = 0;
        if (!(out && mode == 0)) begin
          w[8*(3*r+c) +: 8] = 8'(base + 16*sy + sx);
        end
      end
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int base, input bit gaps, input int npix);
    int nvalid;
    int neol;
    nvalid = 0;
    neol   = 0;
    for (int i = 0; i < npix; i++) begin
      int x;
      int y;
      int ng;
      x  = i % LL;
      y  = i / LL;
      ng = (gaps && i > 0) ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g < ng; g++) begin
        valid = 1'b0;
        sof   = 1'b0;
        tick();
        chk("gap_valid0", 72'(if0.o_valid), 72'(0));
        chk("gap_valid1", 72'(if1.o_valid), 72'(0));
        chk("gap_eol0", 72'(if0.o_eol), 72'(0));
        chk("gap_hold0", if0.o_window, ref_win((i-1) % LL, (i-1) / LL, 0, base));
        chk("gap_hold1", if1.o_window, ref_win((i-1) % LL, (i-1) / LL, 1, base));
      end
      valid = 1'b1;
      sof   = (i == 0);
      data  = 8'(base + 16*y + x);
      tick();
      $display("px %0d (%0d,%0d) data=%02h win0=%h win1=%h int=%0d col=%0d eol=%0d",
               i, x, y, data, if0.o_window, if1.o_window, if0.o_interior, if0.o_col, if0.o_eol);
      nvalid += int'(if0.o_valid);
      neol   += int'(if0.o_eol);
      chk("valid0", 72'(if0.o_valid), 72'(1));
      chk("valid1", 72'(if1.o_valid), 72'(1));
      chk("col0", 72'(if0.o_col), 72'(x));
      chk("col1", 72'(if1.o_col), 72'(x));
      chk("interior0", 72'(if0.o_interior), 72'((x >= 2) && (y >= 2)));
      chk("eol0", 72'(if0.o_eol), 72'(x == LL-1));
      chk("eol1", 72'(if1.o_eol), 72'(x == LL-1));
      chk("win0", if0.o_window, ref_win(x, y, 0, base));
      chk("win1", if1.o_window, ref_win(x, y, 1, base));
      cap0[i] = if0.o_window;
      cap1[i] = if1.o_window;
      capi[i] = if0.o_interior;
    end
    valid = 1'b0;
    sof   = 1'b0;
    if (npix == 16) begin
      chk("valid_count", 72'(nvalid), 72'(16));
      chk("eol_count", 72'(neol), 72'(4));
    end
  endtask

  task automatic table_check();
    for (int k = 0; k < NVEC; k++) begin
      logic [71:0] got;
      got = (vt[k].mode != 0) ? cap1[vt[k].idx] : cap0[vt[k].idx];
      chk($sformatf("vec%0d_win", k), got, vt[k].win);
      chk($sformatf("vec%0d_interior", k), 72'(capi[vt[k].idx]), 72'(vt[k].interior));
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid0"}, 72'(if0.o_valid), 72'(0));
    chk({tag, "_valid1"}, 72'(if1.o_valid), 72'(0));
    chk({tag, "_win0"}, if0.o_window, 72'(0));
    chk({tag, "_win1"}, if1.o_window, 72'(0));
    chk({tag, "_interior0"}, 72'(if0.o_interior), 72'(0));
    chk({tag, "_col0"}, 72'(if0.o_col), 72'(0));
    chk({tag, "_eol0"}, 72'(if0.o_eol), 72'(0));
    chk({tag, "_eol1"}, 72'(if1.o_eol), 72'(0));
  endtask

  initial begin
    vt[0]  = '{10, 0, pk(8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22), 1'b1};
    vt[1]  = '{5,  0, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11), 1'b0};
    vt[2]  = '{0,  0, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0};
    vt[3]  = '{5,  1, pk(8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h10, 8'h10, 8'h11), 1'b0};
    vt[4]  = '{2,  1, pk(8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02), 1'b0};
    vt[5]  = '{15, 0, pk(8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33), 1'b1};
    vt[6]  = '{12, 1, pk(8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h30, 8'h30, 8'h30), 1'b0};
    vt[7]  = '{12, 0, pk(8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h30), 1'b0};
    vt[8]  = '{7,  0, pk(8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13), 1'b0};
    vt[9]  = '{7,  1, pk(8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13), 1'b0};
    vt[10] = '{14, 1, pk(8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32), 1'b1};

    rst   = 1'b1;
    valid = 1'b0;
    sof   = 1'b0;
    data  = '0;
    repeat (3) tick();
    reset_checks("reset");
    rst = 1'b0;

    // Basic gapless frame, then the same frame with random idle gaps.
    run_frame(0, 1'b0, 16);
    table_check();
    run_frame(0, 1'b1, 16);

    // Restart with i_sof on the pixel at (2,1) of a frame in progress.
    run_frame(0, 1'b0, 6);
    run_frame(128, 1'b0, 16);
    chk("sof_win0", cap0[0], pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80));
    chk("sof_win1", cap1[0], {9{8'h80}});
    chk("sof_interior_resume", 72'(capi[10]), 72'(1));

    // Reset during row 2, with a pixel presented in the reset cycle.
    run_frame(0, 1'b0, 9);
    valid = 1'b1;
    data  = 8'h21;
    rst   = 1'b1;
    tick();
    valid = 1'b0;
    rst   = 1'b0;
    reset_checks("midrst");
    tick();
    chk("midrst_idle_valid0", 72'(if0.o_valid), 72'(0));
    run_frame(0, 1'b0, 16);
    table_check();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/kp_window_buffer.md
# kp_window_buffer

Parametrised 3x3 neighbourhood generator for raster-order pixel streams, built on two internal line memories plus a 3x3 tap register array. It accepts one pixel per valid cycle and emits the 3x3 window whose bottom-right tap is that pixel. Frame borders are filled with zeros or replicated edge pixels, and every output is flagged interior or border. It sits between the pixel source and kernel stages (dilate/erode, Sobel, median) in the color-detect pipeline.

## Interface
- DATA_WIDTH, 8, bits per pixel
- LINE_LENGTH, 640, pixels per line; minimum 3
- BORDER_MODE, 0, 0 = out-of-frame taps forced to zero; 1 = out-of-frame taps replicate nearest in-frame pixel
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  pixel accepted this cycle; no backpressure
- i_sof  in  1  qualified by i_valid; this pixel is frame position (0,0)
- i_data  in  DATA_WIDTH  pixel
- o_valid  out  1  window valid, one cycle after the accepted pixel
- o_window  out  9*DATA_WIDTH  tap (r,c) at [DATA_WIDTH*(3r+c) +: DATA_WIDTH]; r=0 is row y-2, r=2 is row y; c=0 is column x-2, c=2 is column x
- o_interior  out  1  all nine taps lie inside the frame (x>=2 and y>=2)
- o_col  out  $clog2(LINE_LENGTH)  column x of tap (2,2)
- o_eol  out  1  o_valid and x == LINE_LENGTH-1

## Operation
- Column counter x: 0..LINE_LENGTH-1, advances on each accepted pixel, wraps to 0. The wrap increments row state y.
- Row state saturates at 2; only y=0, y=1 and y>=2 are distinguished.
- Accepted pixel with i_sof: that pixel is treated as x=0, y=0 regardless of counter state. The next pixel is x=1.
- Line memories LB0 (row y-1) and LB1 (row y-2), each LINE_LENGTH x DATA_WIDTH, addressed by x.
- On accept: read LB0[x] and LB1[x], write LB0[x] <= i_data and LB1[x] <= old LB0[x].
- Tap array: three row shift registers, each 3 deep.
  - Each shifts left on accept.
  - Row 2 loads i_data, row 1 loads old LB0[x], row 0 loads old LB1[x].
- Shift-register contents that cross a line boundary, and stale line-memory contents after reset or i_sof, must never reach o_window unmasked.
- Border rules, with tap (r,c) at source position (x-2+c, y-2+r):
  - BORDER_MODE=0: a tap with negative column or negative row outputs 0.
  - BORDER_MODE=1: the negative coordinate is clamped to 0 (col clamp: x=0 gives all columns x; x=1 gives c0 = c1). Rows are clamped the same way.
- o_interior = (x>=2) && (y>=2), computed for the emitted pixel.
- Frame height is not tracked. The last rows are not flushed and no bottom-border windows are produced.

## Timing
- Latency: pixel accepted at cycle N produces o_valid=1 at N+1 with o_window, o_interior, o_col and o_eol for that pixel.
- i_valid=0 at cycle N: o_valid=0 at N+1; o_window, o_col, o_interior hold their last values. Gaps of any length do not disturb counters, line memories or taps.
- Sustained throughput: one window per cycle.
- Reset:
  - o_valid=0, o_window=0, o_interior=0, o_col=0, o_eol=0.
  - x=0, y=0.
  - Line memories are not cleared; they are masked by the border logic.
- i_rst asserted mid-frame: outputs take reset values the next cycle. A pixel presented in the same cycle as i_rst is dropped.
- i_sof mid-line: counters restart at that pixel. The output for that pixel already shows x=0, y=0 border handling.
- Read-before-write on the same address in the same cycle: the old value goes to the taps. The new value becomes visible one line later.

## Test plan
- Basic window (LINE_LENGTH=4, BORDER_MODE=0): stream a 4x4 frame, pixel = 16y+x, i_sof on the first pixel, i_valid held high.
  - Output for pixel 0x22 -> taps r0..r2 = {00,01,02},{10,11,12},{20,21,22}, o_interior=1, one cycle after accept.
- Zero border: same stream.
  - Pixel 0x11 -> {0,0,0},{0,00,01},{0,10,11}, o_interior=0.
  - Pixel 0x00 -> only tap (2,2)=00, all others 0.
- Replicate border (BORDER_MODE=1): same stream.
  - Pixel 0x11 -> {00,00,01},{00,00,01},{10,10,11}.
  - Pixel 0x02 -> all three rows {00,01,02}.
- Gapped input: insert random i_valid=0 gaps in the basic-window stream.
  - Window sequence identical to the gapless run.
  - o_valid count = 16; o_eol on x=3 of each line.
- Mid-frame i_sof: assert i_sof on the pixel at (2,1) of the 4x4 stream.
  - That output has o_col=0, o_interior=0 and zero-masked taps.
  - Interior windows resume only at new x>=2, y>=2.
- Reset mid-frame: assert i_rst for one cycle during row 2.
  - Next cycle: o_valid=0, o_window=0.
  - Restarted frame with i_sof reproduces the basic-window results exactly.
